// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the scoreboarded register file.
package regfile_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_REG    = 32;

  // INIT walks the array clearing entries; READY serves normal traffic.
  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-producer tracker: one bit per register.
// Reserve sets the bit, writeback clears it, and two read ports query it.
// The caller qualifies the enables (state, x0 filtering).
module regfile_scoreboard #(
  parameter int NUM_REG   = 32,
  parameter int IDX_WIDTH = $clog2(NUM_REG)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rsv_en_i,
  input  logic [IDX_WIDTH-1:0] rsv_rd_i,
  input  logic                 clr_en_i,
  input  logic [IDX_WIDTH-1:0] clr_rd_i,
  input  logic [IDX_WIDTH-1:0] q1_idx_i,
  input  logic [IDX_WIDTH-1:0] q2_idx_i,
  output logic                 q1_pend_o,
  output logic                 q2_pend_o
);

  logic [NUM_REG-1:0] pending_q, pending_d;

  // Next pending vector: the clear is applied first so a same-cycle
  // reserve of the same index wins (the newer producer is outstanding).
  always_comb begin
    pending_d = pending_q;
    if (clr_en_i) pending_d[clr_rd_i] = 1'b0;
    if (rsv_en_i) pending_d[rsv_rd_i] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // Pending bits are cleared by reset; otherwise follow the next-state vector.
  always_ff @(posedge clk) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  assign q1_pend_o = pending_q[q1_idx_i];
  assign q2_pend_o = pending_q[q2_idx_i];

endmodule

// File: rtl/scoreboard_regfile.sv
// Two-read / one-write register file with an issue-time scoreboard.
// After reset, a counter clears every entry before traffic is accepted.
// Optional writeback-to-read forwarding is available.
module scoreboard_regfile
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REG    = DEF_NUM_REG,
  parameter int IDX_WIDTH  = $clog2(NUM_REG),
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IDX_WIDTH-1:0]  rs1,
  input  logic [IDX_WIDTH-1:0]  rs2,
  output logic [DATA_WIDTH-1:0] rs1v,
  output logic [DATA_WIDTH-1:0] rs2v,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  input  logic                  rsv_en,
  input  logic [IDX_WIDTH-1:0]  rsv_rd,
  input  logic                  WEn,
  input  logic [IDX_WIDTH-1:0]  rd,
  input  logic [DATA_WIDTH-1:0] rdv,
  output logic                  init_done
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_REG - 1);
  localparam bit                   FWD      = (BYPASS != 0);

  state_e                state_q, state_d;
  logic [IDX_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REG];

  logic ready, wr_acc, rsv_acc;
  logic fwd1, fwd2, pend1, pend2;

  assign ready   = (state_q == READY);
  assign wr_acc  = ready && WEn && (rd != '0);
  assign rsv_acc = ready && rsv_en && (rsv_rd != '0);

  // Clear-walk FSM: step the counter through every index, then park in READY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        if (cnt_q == LAST_IDX) state_d = READY;
        else                   cnt_d   = cnt_q + IDX_WIDTH'(1);
      end
      READY:   ;
      default: state_d = INIT;
    endcase
  end

  // State and clear counter; reset restarts the walk from index 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage: zero the walked entry in INIT, accept writeback in READY.
  // Nothing is written in a reset cycle, so in-flight writes are dropped.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (!ready)      regs_q[cnt_q] <= '0;
      else if (wr_acc) regs_q[rd]    <= rdv;
    end
  end

  regfile_scoreboard #(
    .NUM_REG   (NUM_REG),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .rsv_en_i  (rsv_acc),
    .rsv_rd_i  (rsv_rd),
    .clr_en_i  (wr_acc),
    .clr_rd_i  (rd),
    .q1_idx_i  (rs1),
    .q2_idx_i  (rs2),
    .q1_pend_o (pend1),
    .q2_pend_o (pend2)
  );

  // A same-cycle writeback to a read source is forwarded when enabled.
  assign fwd1 = FWD && WEn && (rd != '0) && (rd == rs1);
  assign fwd2 = FWD && WEn && (rd != '0) && (rd == rs2);

  // Read ports: x0 and INIT read as zero; otherwise forwarded data or the array.
  always_comb begin
    rs1v     = '0;
    rs2v     = '0;
    rs1_busy = 1'b0;
    rs2_busy = 1'b0;
    if (ready && rs1 != '0) begin
      rs1v     = fwd1 ? rdv : regs_q[rs1];
      rs1_busy = pend1 && !fwd1;
    end
    if (ready && rs2 != '0) begin
      rs2v     = fwd2 ? rdv : regs_q[rs2];
      rs2_busy = pend2 && !fwd2;
    end
  end

  assign init_done = ready;

endmodule

// File: tb/tb_scoreboard_regfile.sv
// Directed bench: a default DUT, a no-forwarding DUT sharing its inputs,
// and a small 8 x 16 instance.
module tb_scoreboard_regfile;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [4:0]  rs1, rs2, rsv_rd, rd;
  logic        rsv_en, WEn;
  logic [31:0] rdv;
  logic [31:0] a_rs1v, a_rs2v, b_rs1v, b_rs2v;
  logic        a_b1, a_b2, b_b1, b_b2, a_done, b_done;

  logic [2:0]  c_rs1, c_rs2, c_rsv_rd, c_rd;
  logic        c_rsv_en, c_WEn;
  logic [15:0] c_rdv, c_rs1v, c_rs2v;
  logic        c_b1, c_b2, c_done;

  scoreboard_regfile dut (
    .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2), .rs1v(a_rs1v), .rs2v(a_rs2v),
    .rs1_busy(a_b1), .rs2_busy(a_b2), .rsv_en(rsv_en), .rsv_rd(rsv_rd),
    .WEn(WEn), .rd(rd), .rdv(rdv), .init_done(a_done));

  scoreboard_regfile #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2), .rs1v(b_rs1v), .rs2v(b_rs2v),
    .rs1_busy(b_b1), .rs2_busy(b_b2), .rsv_en(rsv_en), .rsv_rd(rsv_rd),
    .WEn(WEn), .rd(rd), .rdv(rdv), .init_done(b_done));

  scoreboard_regfile #(.NUM_REG(8), .DATA_WIDTH(16)) dut8 (
    .clk(clk), .rst_n(rst_n), .rs1(c_rs1), .rs2(c_rs2), .rs1v(c_rs1v), .rs2v(c_rs2v),
    .rs1_busy(c_b1), .rs2_busy(c_b2), .rsv_en(c_rsv_en), .rsv_rd(c_rsv_rd),
    .WEn(c_WEn), .rd(c_rd), .rdv(c_rdv), .init_done(c_done));

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] rdv;
    logic        rsv;
    logic [4:0]  rsv_rd;
    logic [4:0]  rs1, rs2;
    logic [31:0] e1, e2;
    logic        b1, b2;
  } vec_t;

  vec_t tv [17];
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic vec_t mk(logic we, logic [4:0] wrd, logic [31:0] wdat,
                              logic rsv, logic [4:0] rrd, logic [4:0] r1, logic [4:0] r2,
                              logic [31:0] e1, logic [31:0] e2, logic b1, logic b2);
    vec_t v;
    v.we = we; v.rd = wrd; v.rdv = wdat; v.rsv = rsv; v.rsv_rd = rrd;
    v.rs1 = r1; v.rs2 = r2; v.e1 = e1; v.e2 = e2; v.b1 = b1; v.b2 = b2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] wrd, input logic [31:0] wdat,
                       input logic rsv, input logic [4:0] rrd,
                       input logic [4:0] r1, input logic [4:0] r2);
    WEn = we; rd = wrd; rdv = wdat; rsv_en = rsv; rsv_rd = rrd; rs1 = r1; rs2 = r2;
  endtask

  // Counts 32 clearing edges; init_done may only rise on the last one.
  task automatic init_walk(input logic drop_at_end);
    for (int k = 1; k <= 32; k++) begin
      if (drop_at_end && k == 32) drive(0, 0, 0, 0, 0, 5'd4, 5'd0);
      tick();
      chk($sformatf("init_done@%0d", k), {31'd0, a_done}, {31'd0, k == 32});
      if (k == 8 || k == 16 || k == 32)
        chk($sformatf("init8_done@%0d", k), {31'd0, c_done}, {31'd0, k >= 8});
      if (k == 16) chk("init_read0", a_rs1v, 32'd0);
    end
  endtask

  initial begin
    // Walk-through of reserve/write/bypass interactions on the default DUT.
    tv[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 5, 0, 32'hDEADBEEF, 0, 0, 0);
    tv[1]  = mk(1, 0, 32'h1,        0, 0, 5, 0, 32'hDEADBEEF, 0, 0, 0);
    tv[2]  = mk(0, 0, 0,            0, 0, 0, 5, 0, 32'hDEADBEEF, 0, 0);
    tv[3]  = mk(0, 0, 0,            1, 3, 3, 3, 0, 0, 0, 0);
    tv[4]  = mk(0, 0, 0,            0, 0, 5, 3, 32'hDEADBEEF, 0, 0, 1);
    tv[5]  = mk(1, 3, 32'h33,       0, 0, 3, 4, 32'h33, 0, 0, 0);
    tv[6]  = mk(0, 0, 0,            0, 0, 3, 3, 32'h33, 32'h33, 0, 0);
    tv[7]  = mk(1, 3, 32'h44,       1, 3, 3, 0, 32'h44, 0, 0, 0);
    tv[8]  = mk(0, 0, 0,            0, 0, 5, 3, 32'hDEADBEEF, 32'h44, 0, 1);
    tv[9]  = mk(0, 0, 0,            1, 0, 0, 0, 0, 0, 0, 0);
    tv[10] = mk(0, 0, 0,            0, 0, 0, 3, 0, 32'h44, 0, 1);
    tv[11] = mk(1, 7, 32'h1234,     0, 0, 7, 7, 32'h1234, 32'h1234, 0, 0);
    tv[12] = mk(0, 0, 0,            1, 7, 7, 3, 32'h1234, 32'h44, 0, 1);
    tv[13] = mk(0, 0, 0,            1, 7, 7, 3, 32'h1234, 32'h44, 1, 1);
    tv[14] = mk(0, 0, 0,            0, 0, 7, 0, 32'h1234, 0, 1, 0);
    tv[15] = mk(1, 3, 32'h55,       0, 0, 3, 3, 32'h55, 32'h55, 0, 0);
    tv[16] = mk(0, 0, 0,            1, 4, 3, 4, 32'h55, 0, 0, 0);

    drive(0, 0, 0, 0, 0, 5, 0);
    c_WEn = 0; c_rd = 0; c_rdv = 0; c_rsv_en = 0; c_rsv_rd = 0; c_rs1 = 0; c_rs2 = 0;
    rst_n = 0;
    tick(); tick();
    chk("reset_done", {31'd0, a_done}, 32'd0);
    chk("reset_read", a_rs1v, 32'd0);
    rst_n = 1;
    init_walk(1'b0);

    // Every entry was cleared by the walk.
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(31 - i);
      #1;
      chk($sformatf("zero_rs1[%0d]", i), a_rs1v, 32'd0);
      chk($sformatf("zero_rs2[%0d]", 31 - i), a_rs2v, 32'd0);
    end

    // 8-entry, 16-bit instance: top index write, bypass and read-back.
    c_WEn = 1; c_rd = 7; c_rdv = 16'hBEEF; c_rs1 = 7; c_rs2 = 6;
    @(negedge clk);
    chk("p8_bypass", {16'd0, c_rs1v}, 32'hBEEF);
    chk("p8_other", {16'd0, c_rs2v}, 32'd0);
    tick();
    c_WEn = 0; c_rsv_en = 1; c_rsv_rd = 7; c_rs2 = 7;
    @(negedge clk);
    chk("p8_read7", {16'd0, c_rs2v}, 32'hBEEF);
    tick();
    c_rsv_en = 0;
    @(negedge clk);
    chk("p8_busy7", {31'd0, c_b1}, 32'd1);

    // Table-driven single-cycle vectors.
    for (int i = 0; i < 17; i++) begin
      drive(tv[i].we, tv[i].rd, tv[i].rdv, tv[i].rsv, tv[i].rsv_rd, tv[i].rs1, tv[i].rs2);
      @(negedge clk);
      chk($sformatf("v%0d_rs1v", i), a_rs1v, tv[i].e1);
      chk($sformatf("v%0d_rs2v", i), a_rs2v, tv[i].e2);
      chk($sformatf("v%0d_b1", i), {31'd0, a_b1}, {31'd0, tv[i].b1});
      chk($sformatf("v%0d_b2", i), {31'd0, a_b2}, {31'd0, tv[i].b2});
      tick();
    end

    // No-forwarding instance: a same-cycle write shows the old value and x7 stays busy.
    drive(1, 7, 32'h1111, 0, 0, 7, 0);
    @(negedge clk);
    chk("nb_old_value", b_rs1v, 32'h1234);
    chk("nb_busy", {31'd0, b_b1}, 32'd1);
    chk("byp_new_value", a_rs1v, 32'h1111);
    tick();
    drive(0, 0, 0, 0, 0, 7, 0);
    @(negedge clk);
    chk("nb_after_write", b_rs1v, 32'h1111);
    chk("nb_busy_cleared", {31'd0, b_b1}, 32'd0);
    tick();

    // Reset in READY with x4 pending; writes/reserves during reset and INIT are dropped.
    drive(0, 0, 0, 0, 0, 4, 0);
    @(negedge clk);
    chk("pre_reset_busy4", {31'd0, a_b1}, 32'd1);
    tick();
    rst_n = 0;
    drive(1, 4, 32'h99, 1, 5, 4, 5);
    tick();
    chk("midreset_done", {31'd0, a_done}, 32'd0);
    chk("midreset_read", a_rs1v, 32'd0);
    rst_n = 1;
    init_walk(1'b1);
    rs2 = 5;
    @(negedge clk);
    chk("post_reset_x4", a_rs1v, 32'd0);
    chk("post_reset_busy4", {31'd0, a_b1}, 32'd0);
    chk("post_reset_busy5", {31'd0, a_b2}, 32'd0);
    rs1 = 3; rs2 = 7;
    @(negedge clk);
    chk("post_reset_x3", a_rs1v, 32'd0);
    chk("post_reset_busy7", {31'd0, a_b2}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/scoreboard_regfile.md
SCOREBOARD_REGFILE -- requirements
Module: scoreboard_regfile

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning register width in bits.
REQ-002 The block SHALL have parameter NUM_REG, default 32, meaning register count (power of two, at least 2).
REQ-003 The block SHALL have parameter IDX_WIDTH, default $clog2(NUM_REG), meaning register index width.
REQ-004 The block SHALL have parameter BYPASS, default 1, meaning 1 enables same-cycle writeback-to-read forwarding.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 The block SHALL have ports rs1 and rs2, input, IDX_WIDTH bits each: read addresses.
REQ-008 The block SHALL have ports rs1v and rs2v, output, DATA_WIDTH bits each: read data.
REQ-009 The block SHALL have ports rs1_busy and rs2_busy, output, 1 bit each: source register has an outstanding producer.
REQ-010 The block SHALL have ports rsv_en (input, 1 bit) and rsv_rd (input, IDX_WIDTH bits): reserve destination at issue.
REQ-011 The block SHALL have ports WEn (input, 1 bit), rd (input, IDX_WIDTH bits) and rdv (input, DATA_WIDTH bits): writeback.
REQ-012 The block SHALL have port init_done, output, 1 bit: high once clearing completes.

Function
REQ-013 Reads SHALL be combinational; rsNv = 0 when rsN == 0 or the state is INIT, otherwise regs[rsN].
REQ-014 With BYPASS=1, a read of rsN SHALL return rdv when WEn && rd == rsN && rd != 0 in the same cycle; with BYPASS=0 the old value is returned.
REQ-015 A write SHALL update regs[rd] at the clock edge when WEn && rd != 0 && state == READY.
REQ-016 The pending[] bit vector SHALL set pending[rsv_rd] at the clock edge when rsv_en && rsv_rd != 0 && state == READY.
REQ-017 An accepted write SHALL clear pending[rd].
REQ-018 A reserve and a write to the same index in the same cycle SHALL leave pending set, because the new producer wins.
REQ-019 Reserving an already-pending register SHALL keep it set and SHALL NOT raise an error.
REQ-020 rsN_busy SHALL equal pending[rsN], forced to 0 for x0 and in INIT, and also forced to 0 when BYPASS=1 with a matching write in the same cycle.
REQ-021 The FSM SHALL have two states, INIT and READY.
REQ-022 In INIT, a clear counter SHALL write 0 to regs[counter] each cycle and increment, and writes and reserves SHALL be ignored.
REQ-023 When the counter reaches NUM_REG-1 and that entry is cleared, the FSM SHALL move to READY and the counter SHALL NOT wrap further.
REQ-024 init_done SHALL be 1 only in READY and SHALL rise after exactly NUM_REG rising edges sampled with rst_n=1.
REQ-025 x0 SHALL never be written, reserved, or reported busy.

Reset
REQ-026 When rst_n=0 at a clock edge, the block SHALL enter INIT with counter=0, all pending bits cleared and init_done=0.
REQ-027 Register contents SHALL be undefined until INIT completes, and outputs SHALL nevertheless read 0 in INIT.
REQ-028 Reset asserted mid-INIT or during READY SHALL restart clearing from index 0, and any in-flight write or reserve in that cycle SHALL be dropped.

Structure
REQ-029 Package regfile_pkg SHALL hold the state enum (INIT, READY) and the default width and count constants.
REQ-030 The pending-bit tracker SHALL be sub-module regfile_scoreboard (reserve, clear, query for 2 ports), and the storage array and FSM SHALL stay in the top level.

Verification
REQ-031 Init: release rst_n -> init_done=0 for 32 cycles, rises on the 32nd edge; every read returns 0 afterwards.
REQ-032 Basic write: WEn=1, rd=5, rdv=0xDEADBEEF -> next cycle rs1=5 gives 0xDEADBEEF; rd=0 write of 0x1 -> rs2=0 still returns 0.
REQ-033 Bypass: same-cycle WEn=1, rd=7, rdv=0x1234 with rs1=7 -> rs1v=0x1234 and rs1_busy=0 (BYPASS=1); with BYPASS=0 rs1v shows the old value.
REQ-034 Scoreboard: reserve rd=3 -> rs2=3 gives rs2_busy=1 next cycle; write rd=3 -> busy=0; reserve and write of 3 together -> busy stays 1; reserve rd=0 -> never busy.
REQ-035 Reset mid-op: rst_n=0 for 1 cycle while x4 is pending in READY -> pending cleared, init_done=0, full 32-cycle INIT again, and a write issued during INIT is ignored.
REQ-036 Parametrised: NUM_REG=8, DATA_WIDTH=16 -> init_done after 8 cycles, and writes and reads at index 7 are correct.
